// File: rtl/iob_uart_txbuf.sv
// rtl/iob_uart_txbuf.sv - byte FIFO that drains into the UART by polling write-wait, then writing data
// Optional sticky overflow flag is built when UART_TXBUF_OVF_EN is defined.

`ifndef UART_ADDR_W
`define UART_ADDR_W 3
`endif
`ifndef UART_WRITE_WAIT
`define UART_WRITE_WAIT 1
`endif
`ifndef UART_DATA
`define UART_DATA 2
`endif

module iob_uart_txbuf #(
  parameter int                DEPTH_LOG2 = 4,
  parameter int                ADDR_W     = `UART_ADDR_W,
  parameter logic [ADDR_W-1:0] WAIT_ADDR  = ADDR_W'(`UART_WRITE_WAIT),
  parameter logic [ADDR_W-1:0] DATA_ADDR  = ADDR_W'(`UART_DATA)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  input  logic [7:0]            s_data,
  output logic                  s_ready,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  busy,
  output logic                  m_valid,
  output logic [ADDR_W-1:0]     m_address,
  output logic [7:0]            m_wdata,
  output logic                  m_wstrb,
  input  logic [31:0]           m_rdata,
  input  logic                  m_ready,
  output logic                  ovf,
  input  logic                  ovf_clr
);

  localparam int                  DEPTH      = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, POLL, WAIT_RD, WRITE, WAIT_WR} state_t;

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic                  push, pop;
  logic                  m_valid_nxt, m_wstrb_nxt;
  logic [ADDR_W-1:0]     m_address_nxt;
  logic [7:0]            m_wdata_nxt;

  assign s_ready = (level != FULL_LEVEL);
  assign push    = s_valid & s_ready;
  assign pop     = (state == WAIT_WR) & m_ready;
  assign busy    = (level != '0) | (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: ;
      endcase
    end
  end

  // State register; the UART-side outputs are registered alongside it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      m_valid   <= 1'b0;
      m_address <= '0;
      m_wdata   <= '0;
      m_wstrb   <= 1'b0;
    end else begin
      state     <= state_nxt;
      m_valid   <= m_valid_nxt;
      m_address <= m_address_nxt;
      m_wdata   <= m_wdata_nxt;
      m_wstrb   <= m_wstrb_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (level != '0) state_nxt = POLL;
      POLL:    state_nxt = WAIT_RD;
      WAIT_RD: if (m_ready) state_nxt = m_rdata[0] ? POLL : WRITE;
      WRITE:   state_nxt = WAIT_WR;
      WAIT_WR: if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requests are keyed on the state being entered so m_valid lines up with POLL/WRITE.
  always_comb begin
    m_valid_nxt   = 1'b0;
    m_address_nxt = m_address;
    m_wstrb_nxt   = m_wstrb;
    m_wdata_nxt   = m_wdata;
    case (state_nxt)
      POLL: begin
        m_valid_nxt   = 1'b1;
        m_address_nxt = WAIT_ADDR;
        m_wstrb_nxt   = 1'b0;
      end
      WRITE: begin
        m_valid_nxt   = 1'b1;
        m_address_nxt = DATA_ADDR;
        m_wstrb_nxt   = 1'b1;
        m_wdata_nxt   = mem[rd_ptr];
      end
      default: ;
    endcase
  end

`ifdef UART_TXBUF_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    ovf <= 1'b0;
    else if (s_valid & ~s_ready) ovf <= 1'b1;
    else if (ovf_clr)            ovf <= 1'b0;
  end
`else
  assign ovf = 1'b0;
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
`endif

  logic unused_rdata;
  assign unused_rdata = ^m_rdata[31:1];

endmodule

// File: tb/tb_iob_uart_txbuf.sv
// tb/tb_iob_uart_txbuf.sv - directed scoreboard bench for iob_uart_txbuf with a polled UART model

module tb_iob_uart_txbuf;

  localparam int             DL     = 4;
  localparam int             AW     = 4;
  localparam logic [AW-1:0]  WAIT_A = 4'h5;
  localparam logic [AW-1:0]  DATA_A = 4'hA;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_ready;
  logic [DL:0]   level;
  logic          busy;
  logic          m_valid;
  logic [AW-1:0] m_address;
  logic [7:0]    m_wdata;
  logic          m_wstrb;
  logic [31:0]   m_rdata;
  logic          m_ready;
  logic          ovf;
  logic          ovf_clr;

  iob_uart_txbuf #(.DEPTH_LOG2(DL), .ADDR_W(AW), .WAIT_ADDR(WAIT_A), .DATA_ADDR(DATA_A)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .level(level), .busy(busy), .m_valid(m_valid), .m_address(m_address),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata), .m_ready(m_ready),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         reads = 0, writes = 0;
  int         busy_polls = 0;
  bit         hold_busy = 0;
  bit         pend = 0, pend_wr = 0, pend_busy = 0, resp_wr = 0;
`ifdef UART_TXBUF_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: advance to the falling edge, drop s_valid, then run the UART model.
  task automatic step();
    logic [7:0] e;
    @(negedge clk);
    s_valid = 1'b0;
    m_ready = pend;
    m_rdata = {31'b0, pend & pend_busy};
    resp_wr = pend && pend_wr;
    if (rst) begin
      pend = 0;
    end else if (m_valid) begin
      check("no_overlap", 32'(m_ready), 32'd0);
      pend = 1;
      if (!m_wstrb) begin
        reads++;
        check("rd_addr", 32'(m_address), 32'(WAIT_A));
        pend_wr   = 0;
        pend_busy = hold_busy || (busy_polls > 0);
        if (busy_polls > 0) busy_polls--;
      end else begin
        writes++;
        check("wr_addr", 32'(m_address), 32'(DATA_A));
        pend_wr   = 1;
        pend_busy = 0;
        check("wr_queued", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_data", 32'(m_wdata), 32'(e));
        end
      end
    end else begin
      pend = 0;
    end
  endtask

  task automatic push(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    if (s_ready) exp_q.push_back(b);
    step();
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || busy); i++) step();
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_q"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_wr_resp(input string tag);
    int n = 0;
    step();
    while (!resp_wr && n < 200) begin
      step();
      n++;
    end
    check(tag, 32'(resp_wr), 32'd1);
  endtask

  int r0, w0;

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; m_rdata = '0; m_ready = 1'b0; ovf_clr = 1'b0;
    #1;
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_m_address", 32'(m_address), 32'd0);
    check("rst_m_wdata", 32'(m_wdata), 32'd0);
    check("rst_m_wstrb", 32'(m_wstrb), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Single byte with an idle UART: latency and per-byte cycle count
    r0 = reads; w0 = writes;
    push(8'h55);
    check("single_level1", 32'(level), 32'd1);
    check("single_pre_valid", 32'(m_valid), 32'd0);
    step();
    check("single_latency", 32'(m_valid), 32'd1);
    repeat (4) step();
    check("single_level0", 32'(level), 32'd0);
    check("single_idle", 32'(busy), 32'd0);
    check("single_reads", 32'(reads - r0), 32'd1);
    check("single_writes", 32'(writes - w0), 32'd1);

    // UART busy for three polls
    r0 = reads; w0 = writes;
    busy_polls = 3;
    push(8'hA3);
    drain("busyuart");
    check("busyuart_reads", 32'(reads - r0), 32'd4);
    check("busyuart_writes", 32'(writes - w0), 32'd1);

    // Fill to full while the UART is held busy, then overflow
    hold_busy = 1;
    for (int i = 0; i < 16; i++) push(8'(i));
    check("full_s_ready", 32'(s_ready), 32'd0);
    check("full_level", 32'(level), 32'd16);
    push(8'hFF);
    check("ovf_set", 32'(ovf), 32'(OVF_EXP));
    check("ovf_level", 32'(level), 32'd16);
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(ovf), 32'd0);
    hold_busy = 0;
    drain("fill");
    for (int i = 16; i < 32; i++) push(8'(i));
    drain("wrap");

    // Push in the same cycle a pop completes
    hold_busy = 1;
    push(8'hC1); push(8'hC2); push(8'hC3);
    check("cc_level3", 32'(level), 32'd3);
    hold_busy = 0;
    wait_wr_resp("cc_wait");
    push(8'h77);
    check("cc_level_hold", 32'(level), 32'd3);
    drain("cc");

    // Asynchronous reset while WAIT_WR has a response pending
    hold_busy = 1;
    for (int i = 0; i < 5; i++) push(8'hE0 + 8'(i));
    hold_busy = 0;
    wait_wr_resp("rst_wait");
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_m_valid", 32'(m_valid), 32'd0);
    check("mid_rst_s_ready", 32'(s_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    r0 = reads; w0 = writes;
    repeat (20) step();
    check("post_rst_reads", 32'(reads - r0), 32'd0);
    check("post_rst_writes", 32'(writes - w0), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
